mem_wb_reg: RTL

MEM/WB pipeline register of the 32-bit MIPS pipeline. It sits directly downstream of the EX/MEM stage and the data-memory access. It captures the MEM-stage result, load data, destination register and write-back controls (MemtoReg, RegWrite). It then drives the register-file write port, the WB-to-EX forwarding path, and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mem_wb_reg.sv | 87 ++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, the write-back control
// bundle that travels EX/MEM -> MEM/WB, and the register-write predicate.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } wb_ctrl_t;

   // A write to $zero is architecturally a no-op, so it never counts as a write.
   function automatic logic is_reg_write(input logic valid,
                                         input logic regwrite,
                                         input logic [REG_AW-1:0] rd);
      return valid & regwrite & (rd != '0);
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the MEM-stage result and drives the
// register-file write port, the WB->EX forwarding path and a retired counter.
module mem_wb_reg #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int REG_AW = mips_pkg::REG_AW,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic              mem_memtoreg,
   input  logic              mem_regwrite,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [REG_AW-1:0] mem_rd,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              fwd_en,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retired_count
);
   import mips_pkg::wb_ctrl_t;
   import mips_pkg::is_reg_write;

   logic              validQ;
   wb_ctrl_t          ctrlQ;
   logic [REG_AW-1:0] rdQ;
   logic [DATA_W-1:0] aluQ;
   logic [DATA_W-1:0] readQ;
   logic              writtenQ;
   logic [CNT_W-1:0]  retiredQ;
   logic              writeCond;

   assign writeCond = is_reg_write(validQ, ctrlQ.regwrite, rdQ);

   // Control priority each edge is flush > stall > load; both are level
   // signals from the hazard unit, there is no back-pressure handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         validQ   <= 1'b0;
         ctrlQ    <= '0;
         rdQ      <= '0;
         aluQ     <= '0;
         readQ    <= '0;
         writtenQ <= 1'b0;
         retiredQ <= '0;
      end else if (flush) begin
         validQ   <= 1'b0;
         ctrlQ    <= '0;
         rdQ      <= '0;
         aluQ     <= '0;
         readQ    <= '0;
         writtenQ <= 1'b0;
      end else if (stall) begin
         // Once the held instruction has written, later stall cycles must not rewrite.
         if (writeCond) begin
            writtenQ <= 1'b1;
         end
      end else begin
         validQ         <= mem_valid;
         ctrlQ.memtoreg <= mem_memtoreg;
         ctrlQ.regwrite <= mem_regwrite;
         rdQ            <= mem_rd;
         aluQ           <= mem_alu_result;
         readQ          <= mem_read_data;
         writtenQ       <= 1'b0;
         if (mem_valid) begin
            retiredQ <= retiredQ + CNT_W'(1);
         end
      end
   end

   assign wb_valid      = validQ;
   assign wb_rd         = rdQ;
   assign wb_data       = ctrlQ.memtoreg ? readQ : aluQ;
   assign wb_we         = writeCond & ~writtenQ;
   assign fwd_en        = writeCond;
   assign fwd_rd        = rdQ;
   assign fwd_data      = wb_data;
   assign retired_count = retiredQ;

endmodule
